// File: rtl/al422_pkg.sv
// Shared AL422 FIFO constants and the writer state encoding.
package al422_pkg;

  localparam int unsigned AL422_DEPTH = 393216;
  localparam int unsigned AL422_CNT_W = 19;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrst  = 2'd1,
    StWlow  = 2'd2,
    StWhigh = 2'd3
  } wr_state_e;

endpackage

// File: rtl/al422_writer_if.sv
// Byte-stream handshake into the AL422 writer; master drives bytes, slave returns ready.
interface al422_writer_if;

  logic [7:0] s_data;
  logic       s_valid;
  logic       s_frame_start;
  logic       s_ready;

  modport master (
    output s_data,
    output s_valid,
    output s_frame_start,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    input  s_frame_start,
    output s_ready
  );

endinterface

// File: rtl/al422_writer.sv
// Streams frame bytes into an AL422 FIFO: write-pointer reset on frame start, one
// WCK pulse per byte, per-frame byte count and sticky overflow at DEPTH.
module al422_writer
  import al422_pkg::*;
#(
  parameter int unsigned WRST_CYCLES = 2,
  parameter int unsigned DEPTH       = AL422_DEPTH
) (
  input  logic                   in_clk,
  input  logic                   in_nrst,
  al422_writer_if.slave          s_if,
  output logic                   al422_wck_out,
  output logic                   al422_nwe_out,
  output logic                   al422_nwrst_out,
  output logic [7:0]             al422_data_out,
  output logic                   overflow,
  output logic [AL422_CNT_W-1:0] frame_bytes
);

  localparam int unsigned WrstLast = 2 * WRST_CYCLES - 1;
  localparam int unsigned WrstW    = (WrstLast > 0) ? $clog2(WrstLast + 1) : 1;
  localparam logic [WrstW-1:0]       WrstLastCnt = WrstW'(WrstLast);
  localparam logic [AL422_CNT_W-1:0] DepthCnt    = AL422_CNT_W'(DEPTH);

  wr_state_e              r_state;
  logic                   r_wck, r_nwe, r_nwrst, r_overflow, r_synced;
  logic [7:0]             r_data, r_pend;
  logic [AL422_CNT_W-1:0] r_cnt, r_frame_bytes;
  logic [WrstW-1:0]       r_wrst_cnt;

  logic w_ready, w_accept, w_start, w_write;

  assign w_ready  = (r_state == StIdle) || (r_state == StWhigh);
  assign w_accept = s_if.s_valid && w_ready;
  assign w_start  = w_accept && s_if.s_frame_start;
  // Bytes before the first frame start, or beyond DEPTH, are accepted but never written.
  assign w_write  = w_accept && !s_if.s_frame_start && r_synced && (r_cnt != DepthCnt);

  assign s_if.s_ready    = w_ready;
  assign al422_wck_out   = r_wck;
  assign al422_nwe_out   = r_nwe;
  assign al422_nwrst_out = r_nwrst;
  assign al422_data_out  = r_data;
  assign overflow        = r_overflow;
  assign frame_bytes     = r_frame_bytes;

  always_ff @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) begin
      r_state       <= StIdle;
      r_wck         <= 1'b0;
      r_nwe         <= 1'b1;
      r_nwrst       <= 1'b1;
      r_data        <= 8'h00;
      r_pend        <= 8'h00;
      r_overflow    <= 1'b0;
      r_synced      <= 1'b0;
      r_cnt         <= '0;
      r_frame_bytes <= '0;
      r_wrst_cnt    <= '0;
    end else begin
      unique case (r_state)
        StIdle, StWhigh: begin
          if (w_start) begin
            r_state    <= StWrst;
            r_nwrst    <= 1'b0;
            r_nwe      <= 1'b1;
            r_wck      <= 1'b1;
            r_pend     <= s_if.s_data;
            r_wrst_cnt <= '0;
          end else if (w_write) begin
            r_state <= StWlow;
            r_data  <= s_if.s_data;
            r_nwe   <= 1'b0;
            r_wck   <= 1'b0;
          end else begin
            r_state <= StIdle;
            r_wck   <= 1'b0;
            r_nwe   <= 1'b1;
          end
        end
        StWrst: begin
          // Last WRST cycle releases nWRST and launches the held frame-start byte.
          if (r_wrst_cnt == WrstLastCnt) begin
            r_state <= StWlow;
            r_nwrst <= 1'b1;
            r_data  <= r_pend;
            r_nwe   <= 1'b0;
            r_wck   <= 1'b0;
          end else begin
            r_wrst_cnt <= r_wrst_cnt + 1'b1;
            r_wck      <= ~r_wck;
          end
        end
        StWlow: begin
          r_state <= StWhigh;
          r_wck   <= 1'b1;
        end
        default: r_state <= StIdle;
      endcase

      if (w_start) begin
        r_frame_bytes <= r_cnt;
        r_cnt         <= AL422_CNT_W'(1);
        r_overflow    <= 1'b0;
        r_synced      <= 1'b1;
      end else if (w_accept && r_synced) begin
        if (r_cnt == DepthCnt) begin
          r_overflow <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/al422_writer.md
AL422_WRITER -- requirements
Module: al422_writer

Interface
REQ-001 Parameter WRST_CYCLES, default 2: number of WCK periods that nWRST is held low per write-pointer reset.
REQ-002 Parameter DEPTH, default 393216: AL422 capacity in bytes.
REQ-003 in_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 in_nrst  input  1  reset, asynchronous, active-low.
REQ-005 s_data  input  8  packet byte stream; header and RGB bytes are passed through unmodified.
REQ-006 s_valid  input  1  s_data valid.
REQ-007 s_frame_start  input  1  qualifies s_data as the first byte of a frame; sampled with s_valid.
REQ-008 s_ready  output  1  byte accepted when s_valid & s_ready at a rising edge.
REQ-009 al422_wck_out  output  1  AL422 write clock.
REQ-010 al422_nwe_out  output  1  AL422 write enable, active-low.
REQ-011 al422_nwrst_out  output  1  AL422 write-pointer reset, active-low.
REQ-012 al422_data_out  output  8  AL422 write data.
REQ-013 overflow  output  1  current frame exceeded DEPTH; sticky until next frame start.
REQ-014 frame_bytes  output  19  byte count of the last completed frame.

Function
REQ-015 FSM states: IDLE, WRST, WLOW, WHIGH; all AL422 outputs registered.
REQ-016 s_ready = 1 in IDLE and WHIGH, 0 in WRST and WLOW (peak rate one byte per 2 in_clk).
REQ-017 Accept without frame start (from IDLE or WHIGH) -> next state WLOW: data_out <= byte, nwe <= 0, wck <= 0.
REQ-018 WLOW -> WHIGH unconditionally: wck <= 1 (AL422 latches byte on this edge); data_out, nwe held.
REQ-019 WHIGH with no accept -> IDLE: wck <= 0, nwe <= 1, data_out held.
REQ-020 Accept with s_frame_start -> WRST: nwrst <= 0, nwe <= 1, byte stored internally.
REQ-021 In WRST, wck toggles every in_clk for 2*WRST_CYCLES cycles, starting high; nwrst <= 1 and the stored byte enters WLOW on the last cycle.
REQ-022 Frame byte counter: 19 bits; on frame start, frame_bytes <= counter and counter <= 1, overflow <= 0; each other accepted byte increments the counter.
REQ-023 Byte accepted with counter == DEPTH -> not written (nwe stays 1, no WCK pulse), overflow <= 1, counter saturates; s_ready is unaffected, so upstream never stalls.
REQ-024 After reset, bytes accepted before the first s_frame_start are dropped (no WCK, no count) because the pointer is unknown.
REQ-025 s_frame_start while overflow = 1: the frame start takes priority (pointer reset, overflow cleared, byte written).
REQ-026 s_frame_start without s_valid is ignored.

Reset
REQ-027 in_nrst low forces asynchronously: state IDLE, wck 0, nwe 1, nwrst 1, data_out 0x00, overflow 0, frame_bytes 0, counter 0, frame-synced flag 0.
REQ-028 Reset mid-write aborts the byte and mid-WRST aborts the pointer reset; the next frame must begin with s_frame_start.

Structure
REQ-029 Shared package al422_pkg holds AL422_DEPTH = 393216, AL422_CNT_W = 19 and the writer state encoding.
REQ-030 Single module; no sub-module is required, with counter and WRST sequencing inline.

Verification
REQ-031 Reset, then frame_start byte 0x25, WRST_CYCLES = 2 -> nwrst low 4 cycles with wck 1,0,1,0, then wck rising with data 0x25 and nwe 0.
REQ-032 Back-to-back bytes 0x01, 0x02, 0x03 with valid held high -> accepted every 2 cycles, three WCK rising edges each with matching data, nwe low throughout, then IDLE.
REQ-033 Byte 0x55 without a prior frame_start after reset -> no WCK edge, nwe stays 1, s_ready stays 1.
REQ-034 DEPTH = 4, frame of 6 bytes -> 4 written, overflow = 1 after 5th; next frame_start -> overflow 0, frame_bytes = 4.
REQ-035 Frame of 1000 bytes, then frame_start -> frame_bytes = 1000.
REQ-036 in_nrst pulsed low during WHIGH -> outputs immediately at reset values; the next non-frame-start byte is dropped.
